wordle_score_ctrl: RTL and testbench

Multi-cycle scoring sequencer for one submitted 5-letter guess against the secret word.
- Runs a green pass, then a yellow pass with per-letter answer consumption, so duplicate letters are scored correctly.
- Writes the resulting 5-cell color row into an internal 6x5 color store, and serves a registered read port for the VGA renderer.
- Sits between the guess state machine (start/done handshake) and the display logic.

---
 rtl/wordle_pkg.sv | 44 ++++
 rtl/wordle_color_store.sv | 62 ++++++
 rtl/wordle_score_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_wordle_score_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wordle_pkg.sv
// wordle_pkg
// Shared definitions for the Wordle scoring slice:
//   - color codes stored per cell (empty / gray / yellow / green)
//   - scoring FSM state encoding
//   - default geometry (rows, letters per word, bits per letter)
//   - helpers to slice a packed word (letter0 in the top byte) and to
//     test whether a byte is an upper-case ASCII letter
package wordle_pkg;

  localparam int DEFAULT_NUM_ROWS = 6;
  localparam int DEFAULT_NUM_COLS = 5;
  localparam int DEFAULT_LETTER_W = 8;
  localparam int WORD_W           = DEFAULT_NUM_COLS * DEFAULT_LETTER_W;

  localparam logic [1:0] COLOR_EMPTY  = 2'b00;
  localparam logic [1:0] COLOR_GRAY   = 2'b01;
  localparam logic [1:0] COLOR_YELLOW = 2'b10;
  localparam logic [1:0] COLOR_GREEN  = 2'b11;

  localparam logic [DEFAULT_LETTER_W-1:0] LETTER_A = 8'h41;
  localparam logic [DEFAULT_LETTER_W-1:0] LETTER_Z = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_WRITE  = 2'd3
  } score_state_t;

  // Letter idx of a packed word; letter 0 occupies the most significant byte.
  function automatic logic [DEFAULT_LETTER_W-1:0] letter_at(
    input logic [WORD_W-1:0] word,
    input logic [2:0]        idx
  );
    int lsb;
    lsb = (DEFAULT_NUM_COLS - 1 - int'(idx)) * DEFAULT_LETTER_W;
    return word[lsb +: DEFAULT_LETTER_W];
  endfunction

  function automatic logic is_upper_letter(input logic [DEFAULT_LETTER_W-1:0] ch);
    return (ch >= LETTER_A) && (ch <= LETTER_Z);
  endfunction

endpackage

// File: rtl/wordle_color_store.sv
// wordle_color_store
// NUM_ROWS x NUM_COLS grid of 2-bit color cells.
// Ports:
//   Clk        system clock, all state on posedge
//   reset      synchronous active-high reset, clears every cell
//   clear_all  synchronous clear of every cell
//   wr_en      write one full row this cycle
//   wr_row     destination row of the write
//   wr_data    packed row colors, column 0 in the top two bits
//   rd_row     read row (VGA side)
//   rd_col     read column (VGA side)
//   rd_color   registered cell color, 1-cycle latency, 00 when out of range
// A read of the row being written in the same cycle returns the old value.
module wordle_color_store
  import wordle_pkg::*;
#(
  parameter int NUM_ROWS = DEFAULT_NUM_ROWS,
  parameter int NUM_COLS = DEFAULT_NUM_COLS
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  clear_all,
  input  logic                  wr_en,
  input  logic [2:0]            wr_row,
  input  logic [2*NUM_COLS-1:0] wr_data,
  input  logic [2:0]            rd_row,
  input  logic [2:0]            rd_col,
  output logic [1:0]            rd_color
);

  localparam logic [2:0] ROW_LIMIT = 3'(NUM_ROWS);
  localparam logic [2:0] COL_LIMIT = 3'(NUM_COLS);

  logic [1:0] cells [NUM_ROWS][NUM_COLS];

  // Cell array: cleared by reset or clear_all, otherwise a whole-row write.
  always_ff @(posedge Clk) begin
    if (reset || clear_all) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          cells[r][c] <= COLOR_EMPTY;
        end
      end
    end else if (wr_en && (wr_row < ROW_LIMIT)) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        cells[wr_row][c] <= wr_data[2*(NUM_COLS-1-c) +: 2];
      end
    end
  end

  // Registered read port; out-of-range coordinates read as empty.
  always_ff @(posedge Clk) begin
    if (reset) begin
      rd_color <= COLOR_EMPTY;
    end else if ((rd_row < ROW_LIMIT) && (rd_col < COL_LIMIT)) begin
      rd_color <= cells[rd_row][rd_col];
    end else begin
      rd_color <= COLOR_EMPTY;
    end
  end

endmodule

// File: rtl/wordle_score_ctrl.sv
// wordle_score_ctrl
// Multi-cycle scorer for one guess against the secret word. A green pass
// (5 cycles) marks exact matches and consumes those answer letters; a yellow
// pass (25 cycles, every guess/answer pair) marks misplaced letters, each
// consuming one unused answer letter so duplicates score correctly. The row
// is then written into the color store. Latency is fixed at 31 cycles.
// Ports:
//   Clk        system clock
//   reset      synchronous active-high reset
//   start      score request, honoured only in IDLE with row_idx < NUM_ROWS
//   guess      guess word, letter0 in [39:32] .. letter4 in [7:0]
//   answer     secret word, same packing
//   row_idx    destination row
//   clear_all  clears the store and aborts scoring (no done pulse)
//   busy       high while scoring
//   done       one-cycle pulse when the row is written (or rejected)
//   win        with done: all five cells green
//   err        with done: guess rejected, nothing written
//   rd_row     VGA read row
//   rd_col     VGA read column
//   rd_color   VGA read data, 1-cycle latency
// Optional feature macro: WORDLE_SCORE_VALIDATE_EN
//   defined   - a guess with any letter outside 'A'..'Z' is rejected at start:
//               done+err pulse on the next cycle, no write, busy stays low
//   undefined - no check, err tied low
module wordle_score_ctrl
  import wordle_pkg::*;
#(
  parameter int NUM_ROWS = DEFAULT_NUM_ROWS,
  parameter int NUM_COLS = DEFAULT_NUM_COLS,
  parameter int LETTER_W = DEFAULT_LETTER_W
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_COLS*LETTER_W-1:0] guess,
  input  logic [NUM_COLS*LETTER_W-1:0] answer,
  input  logic [2:0]                   row_idx,
  input  logic                         clear_all,
  output logic                         busy,
  output logic                         done,
  output logic                         win,
  output logic                         err,
  input  logic [2:0]                   rd_row,
  input  logic [2:0]                   rd_col,
  output logic [1:0]                   rd_color
);

  localparam logic [2:0] ROW_LIMIT = 3'(NUM_ROWS);
  localparam logic [2:0] LAST_IDX  = 3'(NUM_COLS - 1);

  score_state_t            state;
  logic [WORD_W-1:0]       guess_q;
  logic [WORD_W-1:0]       answer_q;
  logic [2:0]              row_q;
  logic [2:0]              i_idx;
  logic [2:0]              j_idx;
  logic [1:0]              col [NUM_COLS];
  logic [NUM_COLS-1:0]     used_ans;
  logic                    all_green;
  logic [2*NUM_COLS-1:0]   row_colors;
  logic                    wr_en;
  logic                    row_ok;
  logic                    letters_eq;

  assign row_ok     = row_idx < ROW_LIMIT;
  assign wr_en      = (state == ST_WRITE) && !clear_all;
  // Green pass compares position i with itself; yellow pass compares i with j.
  assign letters_eq = (letter_at(guess_q, i_idx) ==
                       letter_at(answer_q, (state == ST_GREEN) ? i_idx : j_idx));

  // Pack the working colors for the store and detect a winning row.
  always_comb begin
    all_green  = 1'b1;
    row_colors = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      all_green = all_green && (col[c] == COLOR_GREEN);
      row_colors[2*(NUM_COLS-1-c) +: 2] = col[c];
    end
  end

`ifdef WORDLE_SCORE_VALIDATE_EN
  logic bad_guess;

  // A guess is rejected if any letter is not upper-case ASCII.
  always_comb begin
    bad_guess = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (!is_upper_letter(letter_at(guess, 3'(c)))) begin
        bad_guess = 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

  // Scoring sequencer: IDLE -> GREEN (5) -> YELLOW (25) -> WRITE (1) -> IDLE.
  // clear_all aborts from any state without a done pulse.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      win      <= 1'b0;
`ifdef WORDLE_SCORE_VALIDATE_EN
      err      <= 1'b0;
`endif
      guess_q  <= '0;
      answer_q <= '0;
      row_q    <= '0;
      i_idx    <= '0;
      j_idx    <= '0;
      used_ans <= '0;
      for (int c = 0; c < NUM_COLS; c++) begin
        col[c] <= COLOR_EMPTY;
      end
    end else if (clear_all) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      win   <= 1'b0;
`ifdef WORDLE_SCORE_VALIDATE_EN
      err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      win  <= 1'b0;
`ifdef WORDLE_SCORE_VALIDATE_EN
      err  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start && row_ok) begin
`ifdef WORDLE_SCORE_VALIDATE_EN
            if (bad_guess) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
`endif
              guess_q  <= guess;
              answer_q <= answer;
              row_q    <= row_idx;
              used_ans <= '0;
              i_idx    <= '0;
              j_idx    <= '0;
              for (int c = 0; c < NUM_COLS; c++) begin
                col[c] <= COLOR_GRAY;
              end
              busy  <= 1'b1;
              state <= ST_GREEN;
`ifdef WORDLE_SCORE_VALIDATE_EN
            end
`endif
          end
        end

        ST_GREEN: begin
          if (letters_eq) begin
            col[i_idx]      <= COLOR_GREEN;
            used_ans[i_idx] <= 1'b1;
          end
          if (i_idx == LAST_IDX) begin
            i_idx <= '0;
            j_idx <= '0;
            state <= ST_YELLOW;
          end else begin
            i_idx <= i_idx + 3'd1;
          end
        end

        ST_YELLOW: begin
          // Only still-gray cells may turn yellow, and each answer letter
          // can justify at most one yellow.
          if ((col[i_idx] == COLOR_GRAY) && !used_ans[j_idx] && letters_eq) begin
            col[i_idx]      <= COLOR_YELLOW;
            used_ans[j_idx] <= 1'b1;
          end
          if (j_idx == LAST_IDX) begin
            j_idx <= '0;
            if (i_idx == LAST_IDX) begin
              i_idx <= '0;
              state <= ST_WRITE;
            end else begin
              i_idx <= i_idx + 3'd1;
            end
          end else begin
            j_idx <= j_idx + 3'd1;
          end
        end

        ST_WRITE: begin
          done  <= 1'b1;
          win   <= all_green;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  wordle_color_store #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS)
  ) u_store (
    .Clk       (Clk),
    .reset     (reset),
    .clear_all (clear_all),
    .wr_en     (wr_en),
    .wr_row    (row_q),
    .wr_data   (row_colors),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_color  (rd_color)
  );

endmodule

// File: tb/tb_wordle_score_ctrl.sv
// tb_wordle_score_ctrl
// Self-checking bench for wordle_score_ctrl. Expected colors come from a
// count-based Wordle scoring model; a 6x5 array mirrors the color store.
module tb_wordle_score_ctrl;

  logic        Clk = 1'b0;
  logic        reset;
  logic        start;
  logic [39:0] guess;
  logic [39:0] answer;
  logic [2:0]  row_idx;
  logic        clear_all;
  logic        busy;
  logic        done;
  logic        win;
  logic        err;
  logic [2:0]  rd_row;
  logic [2:0]  rd_col;
  logic [1:0]  rd_color;

  int checks   = 0;
  int failures = 0;
  int exp_store [6][5];

  wordle_score_ctrl dut (
    .Clk       (Clk),
    .reset     (reset),
    .start     (start),
    .guess     (guess),
    .answer    (answer),
    .row_idx   (row_idx),
    .clear_all (clear_all),
    .busy      (busy),
    .done      (done),
    .win       (win),
    .err       (err),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_color  (rd_color)
  );

  always #5 Clk = ~Clk;

  // Hard stop if something hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] letter_of(input logic [39:0] w, input int k);
    return w[39-8*k -: 8];
  endfunction

  // Wordle rules: exact matches are green; remaining answer letters are
  // counted and handed out left to right as yellows; everything else gray.
  function automatic logic [9:0] model_row(input logic [39:0] g, input logic [39:0] a);
    int remaining [256];
    int res [5];
    logic [9:0] packed_row;
    for (int k = 0; k < 256; k++) remaining[k] = 0;
    for (int k = 0; k < 5; k++) begin
      if (letter_of(g, k) == letter_of(a, k)) res[k] = 3;
      else begin
        res[k] = 0;
        remaining[letter_of(a, k)]++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      if (res[k] != 3) begin
        if (remaining[letter_of(g, k)] > 0) begin
          res[k] = 2;
          remaining[letter_of(g, k)]--;
        end else begin
          res[k] = 1;
        end
      end
    end
    packed_row = '0;
    for (int k = 0; k < 5; k++) packed_row[9-2*k -: 2] = 2'(res[k]);
    return packed_row;
  endfunction

  task automatic store_model_row(input int row, input logic [9:0] colors);
    for (int k = 0; k < 5; k++) exp_store[row][k] = int'(colors[9-2*k -: 2]);
  endtask

  task automatic read_cell(input int r, input int c, input int expected, input string tag);
    @(negedge Clk);
    rd_row = 3'(r);
    rd_col = 3'(c);
    @(negedge Clk);
    checkOutput($sformatf("%s r%0d c%0d", tag, r, c), int'(rd_color), expected);
  endtask

  task automatic check_row(input int row, input string tag);
    for (int c = 0; c < 5; c++) read_cell(row, c, exp_store[row][c], tag);
  endtask

  // One full scoring transaction with latency, flag and read-port checks.
  task automatic applyStimulus(input logic [39:0] g, input logic [39:0] a,
                               input int row, input string tag);
    logic [9:0] exp_row;
    int cyc;
    exp_row = model_row(g, a);
    @(negedge Clk);
    guess   = g;
    answer  = a;
    row_idx = 3'(row);
    rd_row  = 3'(row);
    rd_col  = 3'd0;
    start   = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    cyc   = 1;
    checkOutput({tag, " busy"}, int'(busy), 1);
    while (!done && cyc < 40) begin
      @(negedge Clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, 32);
    checkOutput({tag, " win"}, int'(win), int'(exp_row == 10'h3FF));
    checkOutput({tag, " err"}, int'(err), 0);
    checkOutput({tag, " busy_end"}, int'(busy), 0);
    checkOutput({tag, " old_read"}, int'(rd_color), exp_store[row][0]);
    store_model_row(row, exp_row);
    @(negedge Clk);
    checkOutput({tag, " done_pulse"}, int'(done), 0);
    checkOutput({tag, " new_read"}, int'(rd_color), exp_store[row][0]);
    check_row(row, tag);
  endtask

  function automatic logic [39:0] random_word();
    logic [39:0] w;
    for (int k = 0; k < 5; k++) w[39-8*k -: 8] = 8'h41 + 8'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    int done_count;
    reset     = 1'b1;
    start     = 1'b0;
    clear_all = 1'b0;
    guess     = '0;
    answer    = '0;
    row_idx   = '0;
    rd_row    = '0;
    rd_col    = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 5; c++) exp_store[r][c] = 0;

    repeat (3) @(negedge Clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset win", int'(win), 0);
    checkOutput("reset err", int'(err), 0);
    checkOutput("reset rd_color", int'(rd_color), 0);
    reset = 1'b0;

    applyStimulus("CRANE", "CRANE", 0, "crane");
    applyStimulus("PAPAL", "APPLE", 1, "papal");
    applyStimulus("BOBBY", "ABBEY", 2, "bobby");

    // Out-of-range destination row: start ignored.
    @(negedge Clk);
    guess   = "CRANE";
    answer  = "CRANE";
    row_idx = 3'd6;
    start   = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    checkOutput("row6 busy", int'(busy), 0);
    checkOutput("row6 done", int'(done), 0);

    // Out-of-range read coordinates return empty.
    read_cell(6, 0, 0, "oor");
    read_cell(0, 5, 0, "oor");
    read_cell(7, 7, 0, "oor");

    // Randomized runs over a small alphabet to force duplicate letters.
    for (int n = 0; n < 8; n++) begin
      applyStimulus(random_word(), random_word(), int'($urandom_range(0, 5)),
                    $sformatf("rand%0d", n));
    end

    // Second start while busy must be ignored.
    begin
      logic [39:0] g1;
      logic [39:0] a1;
      g1 = random_word();
      a1 = random_word();
      @(negedge Clk);
      guess   = g1;
      answer  = a1;
      row_idx = 3'd3;
      start   = 1'b1;
      @(negedge Clk);
      start      = 1'b0;
      done_count = 0;
      for (int k = 1; k <= 45; k++) begin
        if (done) done_count++;
        if (k == 10) begin
          guess   = "ZZZZZ";
          answer  = "QQQQQ";
          row_idx = 3'd4;
          start   = 1'b1;
        end
        @(negedge Clk);
        start = 1'b0;
      end
      checkOutput("busy_start done_count", done_count, 1);
      store_model_row(3, model_row(g1, a1));
      check_row(3, "busy_start");
      check_row(4, "busy_start");
    end

    // clear_all in the middle of scoring.
    @(negedge Clk);
    guess   = "CRANE";
    answer  = "CRANE";
    row_idx = 3'd5;
    start   = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 1; k < 15; k++) @(negedge Clk);
    clear_all = 1'b1;
    @(negedge Clk);
    clear_all = 1'b0;
    checkOutput("clear busy", int'(busy), 0);
    done_count = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_count++;
      @(negedge Clk);
    end
    checkOutput("clear done_count", done_count, 0);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 5; c++) exp_store[r][c] = 0;
    for (int r = 0; r < 6; r++) check_row(r, "clear");

    // start in the same cycle as clear_all is dropped.
    @(negedge Clk);
    row_idx   = 3'd0;
    start     = 1'b1;
    clear_all = 1'b1;
    @(negedge Clk);
    start     = 1'b0;
    clear_all = 1'b0;
    checkOutput("clear_start busy", int'(busy), 0);

    applyStimulus(random_word(), random_word(), 0, "post_clear");

`ifdef WORDLE_SCORE_VALIDATE_EN
    @(negedge Clk);
    guess   = "CR4NE";
    answer  = "CRANE";
    row_idx = 3'd0;
    start   = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    checkOutput("bad done", int'(done), 1);
    checkOutput("bad err", int'(err), 1);
    checkOutput("bad win", int'(win), 0);
    checkOutput("bad busy", int'(busy), 0);
    @(negedge Clk);
    checkOutput("bad done_pulse", int'(done), 0);
    check_row(0, "bad");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
